motor_ramp: RTL and testbench



---
 rtl/motor_ramp.sv | 107 ++++++++++
 tb/tb_motor_ramp.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/motor_ramp.sv
// Slew-limited ESC speed ramp with arm/disarm sequencing.
// SPEED steps toward a clamped target once per tick while ARMED.
module motor_ramp #(
  parameter int unsigned STEP      = 16,
  parameter int unsigned ARM_TICKS = 8,
  parameter int unsigned MAX_SPD   = 1800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        arm,
  input  logic [10:0] cmd_spd,
  input  logic        cmd_vld,
  output logic        cmd_rdy,
  input  logic [9:0]  off_cfg,
  output logic [10:0] SPEED,
  output logic [9:0]  OFF,
  output logic        armed,
  output logic        at_target
);

  typedef enum logic [1:0] {DISARMED, ARMING, ARMED, STOPPING} state_t;

  localparam logic [11:0] STEP_W   = 12'(STEP);
  localparam logic [10:0] MAX_W    = 11'(MAX_SPD);
  localparam logic [7:0]  CNT_LAST = 8'(ARM_TICKS - 1);

  state_t      state_q;
  logic [10:0] speed_q, tgt_q;
  logic [7:0]  cnt_q;
  logic [9:0]  off_q;
  logic        armed_q;

  logic        up;
  logic [11:0] diff, step_amt, speed_d12;
  logic [10:0] speed_d, cmd_clamped;
  logic        accept;

  always_comb begin
    up          = tgt_q > speed_q;
    diff        = up ? ({1'b0, tgt_q} - {1'b0, speed_q}) : ({1'b0, speed_q} - {1'b0, tgt_q});
    step_amt    = (diff < STEP_W) ? diff : STEP_W;
    speed_d12   = up ? ({1'b0, speed_q} + step_amt) : ({1'b0, speed_q} - step_amt);
    // step never exceeds the distance, so bit 11 only guards against a bad target
    speed_d     = speed_d12[11] ? 11'h7FF : speed_d12[10:0];
    cmd_clamped = (cmd_spd > MAX_W) ? MAX_W : cmd_spd;
  end

  assign cmd_rdy   = !rst && (state_q != STOPPING);
  assign accept    = cmd_vld && cmd_rdy;
  assign SPEED     = speed_q;
  assign OFF       = off_q;
  assign armed     = armed_q;
  assign at_target = (speed_q == tgt_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DISARMED;
      speed_q <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      off_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      if (accept) tgt_q <= cmd_clamped;
      if (state_q == DISARMED) off_q <= off_cfg;
      case (state_q)
        DISARMED: begin
          if (arm) begin
            state_q <= ARMING;
            cnt_q   <= '0;
          end
        end
        ARMING: begin
          if (!arm) begin
            state_q <= DISARMED;
          end else if (tick) begin
            if (cnt_q == CNT_LAST) begin
              state_q <= ARMED;
              armed_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
        end
        ARMED: begin
          if (tick) speed_q <= speed_d;
          if (!arm) begin
            // forced zero target overrides any command accepted this cycle
            state_q <= STOPPING;
            armed_q <= 1'b0;
            tgt_q   <= '0;
          end
        end
        STOPPING: begin
          if (speed_q == 11'd0) state_q <= DISARMED;
          else if (tick) speed_q <= speed_d;
        end
        default: begin
          state_q <= DISARMED;
          armed_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_ramp.sv
// Directed bench for motor_ramp; speed expectations flow through a scoreboard queue.
module tb_motor_ramp;
  logic        clk = 1'b0;
  logic        rst, tick, arm, cmd_vld;
  logic [10:0] cmd_spd;
  logic [9:0]  off_cfg;
  logic        cmd_rdy, armed, at_target;
  logic [10:0] SPEED;
  logic [9:0]  OFF;

  int npass = 0;
  int ntot  = 0;
  int m_spd = 0;
  int m_tgt = 0;
  int exp_q[$];

  motor_ramp dut (
    .clk(clk), .rst(rst), .tick(tick), .arm(arm),
    .cmd_spd(cmd_spd), .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
    .off_cfg(off_cfg), .SPEED(SPEED), .OFF(OFF),
    .armed(armed), .at_target(at_target)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_step(input int spd, input int tgt);
    if (tgt - spd > 16) return spd + 16;
    if (spd - tgt > 16) return spd - 16;
    return tgt;
  endfunction

  task automatic tick_once(input string tag);
    int e;
    exp_q.push_back(model_step(m_spd, m_tgt));
    tick = 1'b1;
    step();
    tick = 1'b0;
    e = exp_q.pop_front();
    m_spd = e;
    chk(tag, SPEED, e);
  endtask

  task automatic accept(input int v, input bit with_tick);
    int e;
    cmd_spd = 11'(v);
    cmd_vld = 1'b1;
    if (with_tick) exp_q.push_back(model_step(m_spd, m_tgt));
    tick = with_tick;
    step();
    cmd_vld = 1'b0;
    tick = 1'b0;
    m_tgt = (v > 1800) ? 1800 : v;
    if (with_tick) begin
      e = exp_q.pop_front();
      m_spd = e;
      chk("accept_tick_speed", SPEED, e);
    end
  endtask

  task automatic ramp_to(input string tag);
    for (int n = 0; n < 300 && m_spd != m_tgt; n++) tick_once(tag);
    chk({tag, "_reached"}, SPEED, m_tgt);
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; arm = 1'b0; cmd_vld = 1'b0; cmd_spd = '0; off_cfg = 10'd256;
    #2;
    chk("rst_speed", SPEED, 0);
    chk("rst_off", OFF, 0);
    chk("rst_armed", armed, 0);
    chk("rst_rdy", cmd_rdy, 0);
    chk("rst_at_target", at_target, 1);
    step();
    rst = 1'b0;
    step();
    chk("off_track_disarmed", OFF, 256);
    chk("rdy_disarmed", cmd_rdy, 1);

    // aborted arming: 5 ticks then drop arm
    arm = 1'b1;
    step();
    off_cfg = 10'd100;
    for (int i = 0; i < 5; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      chk("abort_armed_low", armed, 0);
    end
    chk("off_frozen_arming", OFF, 256);
    arm = 1'b0;
    step();
    chk("abort_armed_after", armed, 0);
    step();
    chk("off_track_again", OFF, 100);
    off_cfg = 10'd256;
    step();

    // full arming: armed rises right after the 8th tick
    arm = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      tick = 1'b1; step(); tick = 1'b0;
      chk("arm_seq", armed, (i == 7) ? 1 : 0);
    end
    chk("rdy_armed", cmd_rdy, 1);
    off_cfg = 10'd5;
    step();
    chk("off_frozen_armed", OFF, 256);

    // ramp up to 100
    accept(100, 1'b0);
    chk("no_tick_no_move", SPEED, 0);
    ramp_to("ramp_up");
    chk("at_target_100", at_target, 1);
    tick_once("hold_100");
    tick_once("hold_100b");

    // clamp to MAX_SPD, then one-tick down step
    accept(2047, 1'b0);
    chk("clamp_at_target_low", at_target, 0);
    step();
    chk("idle_no_move", SPEED, 100);
    ramp_to("ramp_clamp");
    chk("clamp_1800", SPEED, 1800);
    accept(1790, 1'b0);
    tick_once("down_1790");
    chk("at_target_1790", at_target, 1);

    // tick + new command in the same cycle steps toward the old target
    accept(1000, 1'b0);
    accept(1790, 1'b1);
    chk("simul_old_target", SPEED, 1774);
    tick_once("simul_new_target");

    // disarm from 40: 24, 8, 0, then DISARMED; arm=1 ignored meanwhile
    accept(40, 1'b0);
    ramp_to("ramp_40");
    arm = 1'b0;
    step();
    m_tgt = 0;
    chk("stop_rdy", cmd_rdy, 0);
    chk("stop_armed", armed, 0);
    arm = 1'b1;
    tick_once("stop_24");
    tick_once("stop_8");
    tick_once("stop_0");
    chk("stop_rdy_at_zero", cmd_rdy, 0);
    step();
    chk("disarmed_rdy", cmd_rdy, 1);
    chk("disarmed_armed", armed, 0);
    chk("off_frozen_stop", OFF, 256);
    arm = 1'b0;
    off_cfg = 10'd77;
    step();
    chk("off_track_77", OFF, 77);

    // async reset mid-ramp at SPEED 500
    arm = 1'b1;
    step();
    tick = 1'b1;
    for (int i = 0; i < 8; i++) step();
    tick = 1'b0;
    chk("rearm", armed, 1);
    accept(500, 1'b0);
    ramp_to("ramp_500");
    accept(1000, 1'b0);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_speed", SPEED, 0);
    chk("arst_off", OFF, 0);
    chk("arst_armed", armed, 0);
    chk("arst_rdy", cmd_rdy, 0);
    chk("arst_at_target", at_target, 1);
    #1 rst = 1'b0;
    arm = 1'b0;
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("post_rst_speed", SPEED, 0);
    chk("post_rst_rdy", cmd_rdy, 1);
    chk("post_rst_at_target", at_target, 1);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
